ef_pwm32_capture: RTL and testbench

EF_PWM32_CAPTURE -- requirements
Module: EF_PWM32_CAPTURE

---
 rtl/ef_pwm32_capture_pkg.sv | 19 +
 rtl/ef_pwm32_capture_edge.sv | 68 ++++++
 rtl/ef_pwm32_capture.sv | 146 ++++++++++++++
 tb/tb_ef_pwm32_capture.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_pwm32_capture_pkg.sv
// rtl/ef_pwm32_capture_pkg.sv - shared FSM state type, counter width and saturation constants
package ef_pwm32_capture_pkg;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_ONE = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/ef_pwm32_capture_edge.sv
// rtl/ef_pwm32_capture_edge.sv - pwm input synchronizer, optional glitch filter (EF_PWM32_CAPTURE_GLITCH_FILTER_EN) and edge detector
module ef_pwm32_capture_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    input  logic inv_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic level_d;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i ^ inv_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef EF_PWM32_CAPTURE_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // The filtered level only moves once three consecutive samples agree.
    always_comb begin
        level_d = level_q;
        if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
            level_d = sync2_q;
        end
    end
`else
    assign level_d = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ef_pwm32_capture.sv
// rtl/ef_pwm32_capture.sv - PWM period/high-time capture; optional input glitch filter via EF_PWM32_CAPTURE_GLITCH_FILTER_EN
module ef_pwm32_capture
    import ef_pwm32_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             en,
    input  logic             inv,
    input  logic [3:0]       clkdiv,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [3:0]       presc_q, presc_d;
    logic [3:0]       div_q, div_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;
    logic             rise;
    logic             fall;
    logic             counting;
    logic             tick;
    logic [CNT_W-1:0] cnt_inc;

    ef_pwm32_capture_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_i  (pwm_in),
        .inv_i  (inv),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign counting = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign tick     = counting && (presc_q == div_q);
    assign cnt_inc  = sat_inc(cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        presc_d  = presc_q;
        div_d    = div_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        sat_d    = sat_q;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            // A new divider is only picked up at a prescaler wrap so a tick never gets lost.
            if (counting) begin
                presc_d = tick ? 4'd0 : presc_q + 4'd1;
                if (tick) begin
                    div_d = clkdiv;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_SAT) begin
                        ovf_d = 1'b1;
                        sat_d = 1'b1;
                    end
                end
            end else begin
                div_d = clkdiv;
            end

            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ONE;
                        presc_d = 4'd0;
                        sat_d   = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        presc_d = 4'd0;
                        sat_d   = 1'b0;
                    end else if (fall) begin
                        hi_d    = cnt_q;
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hi_q;
                        valid_d  = 1'b1;
                        ovf_d    = sat_q;
                        cnt_d    = CNT_ONE;
                        presc_d  = 4'd0;
                        sat_d    = 1'b0;
                        state_d  = ST_HIGH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            presc_q  <= 4'd0;
            div_q    <= 4'd0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            presc_q  <= presc_d;
            div_q    <= div_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ef_pwm32_capture.sv
// tb/tb_ef_pwm32_capture.sv - scoreboard bench for ef_pwm32_capture (EF_PWM32_CAPTURE_GLITCH_FILTER_EN adds filter tests)
module tb_ef_pwm32_capture;
    import ef_pwm32_capture_pkg::*;

    typedef struct {
        logic [31:0] period;
        logic [31:0] high;
        logic        ovf;
        int          gap;
    } exp_t;

`ifdef EF_PWM32_CAPTURE_GLITCH_FILTER_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 3;
`endif

    exp_t        sb[$];
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        inv = 1'b0;
    logic [3:0]  clkdiv = 4'd0;
    logic        man_pwm = 1'b0;
    logic        gen_on = 1'b0;
    logic        gen_pwm = 1'b0;
    int          gen_hi = 5;
    int          gen_lo = 8;
    int          gen_cnt = 0;
    logic        pwm_in;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        valid;
    logic        ovf;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    assign pwm_in = gen_on ? gen_pwm : man_pwm;

    ef_pwm32_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .en        (en),
        .inv       (inv),
        .clkdiv    (clkdiv),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (gen_on) begin
            gen_pwm = (gen_cnt < gen_hi);
            gen_cnt = (gen_cnt + 1 == gen_hi + gen_lo) ? 0 : gen_cnt + 1;
        end else begin
            gen_pwm = 1'b0;
            gen_cnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] p, input logic [31:0] h, input logic o, input int g);
        exp_t e;
        e.period = p;
        e.high   = h;
        e.ovf    = o;
        e.gap    = g;
        sb.push_back(e);
    endtask

    task automatic arm();
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic collect(input int n, input int budget, input string name);
        exp_t e;
        int got = 0;
        int waited = 0;
        int last = -1;
        int extra = 0;
        while (got < n && waited < budget) begin
            @(negedge clk);
            waited++;
            if (valid === 1'b1) begin
                got++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s unexpected_valid period=%0h high=%0h", name, period, high_time);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (period !== e.period) begin
                        failures++;
                        $display("FAIL %s period got=%0h exp=%0h", name, period, e.period);
                    end
                    checks++;
                    if (high_time !== e.high) begin
                        failures++;
                        $display("FAIL %s high_time got=%0h exp=%0h", name, high_time, e.high);
                    end
                    checks++;
                    if (ovf !== e.ovf) begin
                        failures++;
                        $display("FAIL %s ovf got=%0b exp=%0b", name, ovf, e.ovf);
                    end
                    if (e.gap != 0) begin
                        checks++;
                        if (cyc - last !== e.gap) begin
                            failures++;
                            $display("FAIL %s valid_gap got=%0d exp=%0d", name, cyc - last, e.gap);
                        end
                    end
                end
                last = cyc;
            end
        end
        gen_on = 1'b0;
        checks++;
        if (got !== n) begin
            failures++;
            $display("FAIL %s valid_count got=%0d exp=%0d (timeout)", name, got, n);
        end
        repeat (20) begin
            @(negedge clk);
            if (valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL %s extra_valids got=%0d exp=0", name, extra);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s leftover_expect got=%0d exp=0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL reset_period got=%0h exp=0", period); end
        checks++; if (high_time !== 32'd0) begin failures++; $display("FAIL reset_high got=%0h exp=0", high_time); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_edge_latency();
        int lat = 0;
        en = 1'b0;
        man_pwm = 1'b0;
        repeat (8) @(negedge clk);
        man_pwm = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat == 0 && dut.u_edge.rise_o === 1'b1) lat = k;
        end
        checks++;
        if (lat !== EXP_LAT) begin
            failures++;
            $display("FAIL edge_latency got=%0d exp=%0d", lat, EXP_LAT);
        end
        man_pwm = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        clkdiv = 4'd0;
        arm();
        push(32'd13, 32'd5, 1'b0, 0);
        for (int i = 0; i < 3; i++) push(32'd13, 32'd5, 1'b0, 13);
        gen_hi = 5; gen_lo = 8;
        gen_on = 1'b1;
        collect(4, 300, "basic_5_8");
    endtask

    task automatic test_prescaler();
        en = 1'b0;
        clkdiv = 4'd3;
        arm();
        push(32'd10, 32'd5, 1'b0, 0);
        for (int i = 0; i < 2; i++) push(32'd10, 32'd5, 1'b0, 40);
        gen_hi = 20; gen_lo = 20;
        gen_on = 1'b1;
        collect(3, 600, "prescaler_div3");
        en = 1'b0;
        clkdiv = 4'd0;
    endtask

    task automatic test_invert();
        en = 1'b0;
        inv = 1'b1;
        repeat (8) @(negedge clk);
        arm();
        push(32'd13, 32'd8, 1'b0, 0);
        for (int i = 0; i < 2; i++) push(32'd13, 32'd8, 1'b0, 13);
        gen_hi = 5; gen_lo = 8;
        gen_on = 1'b1;
        collect(3, 300, "invert");
        en = 1'b0;
        inv = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_en_drop();
        int seen = 0;
        arm();
        man_pwm = 1'b1;
        repeat (8) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_busy got=%0b exp=0", busy);
        end
        repeat (10) begin
            @(negedge clk);
            if (valid === 1'b1) seen++;
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL en_rearm_busy got=%0b exp=1", busy);
        end
        man_pwm = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL en_drop_valid got=%0d exp=0", seen);
        end
        push(32'd13, 32'd5, 1'b0, 0);
        push(32'd13, 32'd5, 1'b0, 13);
        gen_hi = 5; gen_lo = 8;
        gen_on = 1'b1;
        collect(2, 300, "en_rearm");
    endtask

    task automatic test_saturation();
        arm();
        man_pwm = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat_pre_ovf got=%0b exp=0", ovf);
        end
        force dut.cnt_q = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.cnt_q;
        repeat (30) @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf_set got=%0b exp=1", ovf);
        end
        man_pwm = 1'b0;
        repeat (8) @(negedge clk);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        push(32'd13, 32'd5, 1'b0, 13);
        gen_hi = 5; gen_lo = 8;
        gen_on = 1'b1;
        collect(2, 300, "saturation");
    endtask

    task automatic test_reset_mid();
        arm();
        push(32'd13, 32'd5, 1'b0, 0);
        gen_hi = 5; gen_lo = 8;
        gen_on = 1'b1;
        collect(1, 300, "pre_reset");
        gen_on = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        gen_on = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL midreset_period got=%0h exp=0", period); end
        checks++; if (high_time !== 32'd0) begin failures++; $display("FAIL midreset_high got=%0h exp=0", high_time); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        push(32'd13, 32'd5, 1'b0, 0);
        push(32'd13, 32'd5, 1'b0, 13);
        gen_on = 1'b1;
        collect(2, 300, "post_reset");
    endtask

    task automatic test_glitch_filter();
`ifdef EF_PWM32_CAPTURE_GLITCH_FILTER_EN
        int moved = 0;
        int lat = 0;
        arm();
        man_pwm = 1'b1;
        repeat (2) @(negedge clk);
        man_pwm = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dut.state_q != ST_ARM) moved++;
        end
        checks++;
        if (moved !== 0) begin
            failures++;
            $display("FAIL glitch_2cyc_state_moves got=%0d exp=0", moved);
        end
        man_pwm = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) man_pwm = 1'b0;
            if (lat == 0 && dut.u_edge.rise_o === 1'b1) lat = k;
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL pulse_3cyc_latency got=%0d exp=5", lat);
        end
        checks++;
        if (dut.state_q !== ST_HIGH) begin
            failures++;
            $display("FAIL pulse_3cyc_state got=%0d exp=%0d", dut.state_q, ST_HIGH);
        end
        en = 1'b0;
        repeat (10) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_basic();
        test_prescaler();
        test_invert();
        test_en_drop();
        test_saturation();
        test_reset_mid();
        test_glitch_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
